alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu.sv | 35 +++
 rtl/alu_rr_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and default widths.
// Imported by the ALU, the round-robin picker and the arbiter top.
package alu_arbiter_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_CTRL_W = 4;
    localparam int DEFAULT_CNT_W  = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/unsigned SLT with a zero flag.
// Unknown control codes yield a zero result.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CTRL_W = DEFAULT_CTRL_W
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  result,
    output logic              zero
);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(ALU_AND);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(ALU_OR);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(ALU_ADD);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(ALU_SUB);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(ALU_SLT);

    always_comb begin
        result = '0;
        case (ctrl)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = WIDTH'(a < b);
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: grants the sole eligible requester, or the one
// named by rr_ptr on contention, and hands priority to the loser afterwards.
module alu_rr_pick
    import alu_arbiter_pkg::*;
(
    input  logic elig_0,
    input  logic elig_1,
    input  logic rr_ptr,
    output logic grant_0,
    output logic grant_1,
    output logic rr_ptr_next
);

    always_comb begin
        grant_0     = elig_0 && (!elig_1 || (rr_ptr == RR_REQ0));
        grant_1     = elig_1 && (!elig_0 || (rr_ptr == RR_REQ1));
        rr_ptr_next = rr_ptr;
        if (grant_0) begin
            rr_ptr_next = RR_REQ1;
        end else if (grant_1) begin
            rr_ptr_next = RR_REQ0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX stage (req 0) and the
// address/branch unit (req 1), with registered per-requester response slots.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,

    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0]  rsp0_result_q, rsp0_result_d;
    logic              rsp0_zero_q, rsp0_zero_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0]  rsp1_result_q, rsp1_result_d;
    logic              rsp1_zero_q, rsp1_zero_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
    logic              rr_ptr_q, rr_ptr_d;

    logic              elig_0, elig_1;
    logic              grant_0, grant_1;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_zero;

    // A full slot is still eligible when it is being drained this cycle.
    assign elig_0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig_1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

    alu_rr_pick u_pick (
        .elig_0      (elig_0),
        .elig_1      (elig_1),
        .rr_ptr      (rr_ptr_q),
        .grant_0     (grant_0),
        .grant_1     (grant_1),
        .rr_ptr_next (rr_ptr_d)
    );

    assign alu_a    = grant_1 ? req1_a    : req0_a;
    assign alu_b    = grant_1 ? req1_b    : req0_b;
    assign alu_ctrl = grant_1 ? req1_ctrl : req0_ctrl;

    alu #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // A new grant wins over a same-cycle drain of the slot.
    always_comb begin
        rsp0_valid_d  = rsp0_valid_q && !rsp0_ready;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        if (grant_0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
        end

        rsp1_valid_d  = rsp1_valid_q && !rsp1_ready;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant_1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (elig_0 && elig_1 && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q   <= 1'b0;
            rsp0_result_q  <= '0;
            rsp0_zero_q    <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp1_result_q  <= '0;
            rsp1_zero_q    <= 1'b0;
            conflict_cnt_q <= '0;
            rr_ptr_q       <= RR_REQ0;
        end else begin
            rsp0_valid_q   <= rsp0_valid_d;
            rsp0_result_q  <= rsp0_result_d;
            rsp0_zero_q    <= rsp0_zero_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp1_result_q  <= rsp1_result_d;
            rsp1_zero_q    <= rsp1_zero_d;
            conflict_cnt_q <= conflict_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign req0_ready   = grant_0;
    assign req1_ready   = grant_1;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_result  = rsp0_result_q;
    assign rsp0_zero    = rsp0_zero_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_result  = rsp1_result_q;
    assign rsp1_zero    = rsp1_zero_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (CNT_W=4 so counter saturation is reachable);
// expected values are hand-computed constants.
module tb_alu_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0]  rsp0_result, rsp1_result;
    logic              rsp0_zero, rsp1_zero;
    logic [CNT_W-1:0]  conflict_cnt;

    int compared   = 0;
    int mismatched = 0;

    alu_arbiter #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ctrl    (req0_ctrl),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ctrl    (req1_ctrl),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_result  (rsp0_result),
        .rsp0_zero    (rsp0_zero),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_result  (rsp1_result),
        .rsp1_zero    (rsp1_zero),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] c0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [3:0] c1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        #1;
    endtask

    logic [31:0] vec_a    [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF,
                                  32'h0000_F0F0, 32'h0000_F0F0, 32'h3};
    logic [31:0] vec_b    [7] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h1,
                                  32'h0000_FF00, 32'h0000_FF00, 32'h5};
    logic [3:0]  vec_ctrl [7] = '{4'b0010, 4'b0111, 4'b0111, 4'b1100,
                                  4'b0000, 4'b0001, 4'b0110};
    logic [31:0] vec_res  [7] = '{32'h0, 32'h0, 32'h1, 32'h0,
                                  32'h0000_F000, 32'h0000_FFF0, 32'hFFFF_FFFE};
    logic        vec_zero [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 32'h0);
        checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 32'h0);
        checkOutput("reset_rsp0_result", rsp0_result, 32'h0);
        checkOutput("reset_rsp1_zero", 32'(rsp1_zero), 32'h0);
        checkOutput("reset_cnt", 32'(conflict_cnt), 32'h0);
        checkOutput("reset_req0_ready", 32'(req0_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from req0: ADD 5+3
        tick();
        applyStimulus(1'b1, 32'd5, 32'd3, 4'b0010, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t1_req0_ready", 32'(req0_ready), 32'h1);
        checkOutput("t1_req1_ready", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        checkOutput("t1_rsp0_valid", 32'(rsp0_valid), 32'h1);
        checkOutput("t1_rsp0_result", rsp0_result, 32'd8);
        checkOutput("t1_rsp0_zero", 32'(rsp0_zero), 32'h0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        checkOutput("t1_rsp0_drained", 32'(rsp0_valid), 32'h0);
        checkOutput("t1_cnt", 32'(conflict_cnt), 32'h0);

        // Contention: rr_ptr now favours req1, so grants go 1,0,1,0
        applyStimulus(1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd7, 32'd7, 4'b0110);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_req0_ready_%0d", i), 32'(req0_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput($sformatf("t2_req1_ready_%0d", i), 32'(req1_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            tick();
            checkOutput($sformatf("t2_cnt_%0d", i), 32'(conflict_cnt), 32'(i + 1));
            if (i % 2 == 0) begin
                checkOutput($sformatf("t2_rsp1_valid_%0d", i), 32'(rsp1_valid), 32'h1);
                checkOutput($sformatf("t2_rsp1_result_%0d", i), rsp1_result, 32'h0);
                checkOutput($sformatf("t2_rsp1_zero_%0d", i), 32'(rsp1_zero), 32'h1);
                checkOutput($sformatf("t2_rsp0_valid_%0d", i), 32'(rsp0_valid), 32'h0);
            end else begin
                checkOutput($sformatf("t2_rsp0_valid_%0d", i), 32'(rsp0_valid), 32'h1);
                checkOutput($sformatf("t2_rsp0_result_%0d", i), rsp0_result, 32'd2);
                checkOutput($sformatf("t2_rsp1_valid_%0d", i), 32'(rsp1_valid), 32'h0);
            end
        end

        // rsp0 full and stalled: req0 blocked, req1 granted alone
        rsp0_ready = 1'b0;
        applyStimulus(1'b1, 32'd10, 32'd20, 4'b0010, 1'b1, 32'd9, 32'd4, 4'b0110);
        checkOutput("t3_req0_blocked", 32'(req0_ready), 32'h0);
        checkOutput("t3_req1_alone", 32'(req1_ready), 32'h1);
        tick();
        req1_valid = 1'b0;
        checkOutput("t3_rsp1_result", rsp1_result, 32'd5);
        checkOutput("t3_rsp0_held_valid", 32'(rsp0_valid), 32'h1);
        checkOutput("t3_rsp0_held_result", rsp0_result, 32'd2);
        checkOutput("t3_cnt", 32'(conflict_cnt), 32'd4);
        rsp0_ready = 1'b1;
        #1;
        checkOutput("t3_req0_regrant", 32'(req0_ready), 32'h1);
        tick();
        checkOutput("t3_rsp0_valid_kept", 32'(rsp0_valid), 32'h1);
        checkOutput("t3_rsp0_new_result", rsp0_result, 32'd30);
        checkOutput("t3_rsp1_drained", 32'(rsp1_valid), 32'h0);

        // Operand boundaries and an undefined control code on req0
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vec_a[i], vec_b[i], vec_ctrl[i], 1'b0, 32'h0, 32'h0, 4'h0);
            checkOutput($sformatf("t4_ready_%0d", i), 32'(req0_ready), 32'h1);
            tick();
            checkOutput($sformatf("t4_valid_%0d", i), 32'(rsp0_valid), 32'h1);
            checkOutput($sformatf("t4_result_%0d", i), rsp0_result, vec_res[i]);
            checkOutput($sformatf("t4_zero_%0d", i), 32'(rsp0_zero), 32'(vec_zero[i]));
        end

        // Sustained contention drives the 4-bit counter into saturation
        exp_cnt = 4;
        applyStimulus(1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd7, 32'd7, 4'b0110);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < 15) exp_cnt++;
            checkOutput($sformatf("t5_cnt_%0d", i), 32'(conflict_cnt), 32'(exp_cnt));
        end
        checkOutput("t5_cnt_saturated", 32'(conflict_cnt), 32'd15);

        // Fill rsp1, then reset asynchronously between clock edges
        rsp1_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'd8, 32'd3, 4'b0110);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t6_rsp1_valid_pre", 32'(rsp1_valid), 32'h1);
        checkOutput("t6_rsp1_result_pre", rsp1_result, 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rsp1_valid_rst", 32'(rsp1_valid), 32'h0);
        checkOutput("t6_rsp1_result_rst", rsp1_result, 32'h0);
        checkOutput("t6_rsp0_valid_rst", 32'(rsp0_valid), 32'h0);
        checkOutput("t6_rsp0_result_rst", rsp0_result, 32'h0);
        checkOutput("t6_cnt_rst", 32'(conflict_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        applyStimulus(1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd7, 32'd7, 4'b0110);
        checkOutput("t6_req0_first", 32'(req0_ready), 32'h1);
        checkOutput("t6_req1_waits", 32'(req1_ready), 32'h0);
        tick();
        checkOutput("t6_rsp0_after", rsp0_result, 32'd2);
        checkOutput("t6_cnt_after", 32'(conflict_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
